// File: rtl/nes_controller_reader.sv
// NES controller reader: generates latch/shift strobes at a divided tick rate,
// shifts in the 8 active-low buttons and publishes them as an active-high word.
module nes_controller_reader #(
   parameter int CLK_DIV    = 300,
   parameter int POLL_TICKS = 2762
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        nes_data,
   output logic        nes_latch,
   output logic        nes_clk,
   output logic [15:0] nes_input,
   output logic        frame_done
);

   localparam int DIV_W  = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
   localparam int POLL_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;

   typedef enum logic [1:0] {IDLE, LATCH, CLK_HIGH, CLK_LOW} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic [POLL_W-1:0] idle_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic              latch_second;
   logic              load_pending;
   logic              data_meta;
   logic              data_sync;

   // Synchronizer idles at 1, the released level of the active-low data line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         data_meta <= nes_data;
         data_sync <= data_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop in this
   // block samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         idle_cnt     <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         latch_second <= 1'b0;
         load_pending <= 1'b0;
         nes_latch    <= 1'b0;
         nes_clk      <= 1'b0;
         nes_input    <= '0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         // Publish one cycle after the last bit so the word is always whole.
         if (load_pending) begin
            nes_input    <= {8'h00, shift};
            frame_done   <= 1'b1;
            load_pending <= 1'b0;
         end

         if (tick) begin
            case (state)
               IDLE: begin
                  if (idle_cnt == POLL_W'(POLL_TICKS - 1)) begin
                     idle_cnt     <= '0;
                     bit_idx      <= '0;
                     latch_second <= 1'b0;
                     nes_latch    <= 1'b1;
                     state        <= LATCH;
                  end else begin
                     idle_cnt <= idle_cnt + POLL_W'(1);
                  end
               end

               LATCH: begin
                  if (!latch_second) begin
                     latch_second <= 1'b1;
                  end else begin
                     shift     <= {~data_sync, shift[7:1]};
                     bit_idx   <= 3'd1;
                     nes_latch <= 1'b0;
                     nes_clk   <= 1'b1;
                     state     <= CLK_HIGH;
                  end
               end

               CLK_HIGH: begin
                  nes_clk <= 1'b0;
                  state   <= CLK_LOW;
               end

               CLK_LOW: begin
                  shift   <= {~data_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     load_pending <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     nes_clk <= 1'b1;
                     state   <= CLK_HIGH;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: a 4021-style controller model plus a
// frame-position reference that predicts every output on every cycle.
module tb_nes_controller_reader;

   localparam int CLK_DIV    = 4;
   localparam int POLL_TICKS = 10;
   localparam int FRAME      = (POLL_TICKS + 16) * CLK_DIV;
   localparam int LATCH_AT   = POLL_TICKS * CLK_DIV;
   localparam int SHIFT_AT   = LATCH_AT + 2 * CLK_DIV;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        nes_data;
   logic        nes_latch;
   logic        nes_clk;
   logic [15:0] nes_input;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nes_controller_reader #(
      .CLK_DIV   (CLK_DIV),
      .POLL_TICKS(POLL_TICKS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .nes_data  (nes_data),
      .nes_latch (nes_latch),
      .nes_clk   (nes_clk),
      .nes_input (nes_input),
      .frame_done(frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Controller: parallel-load while latched, advance one button per nes_clk rise.
   logic [7:0] pressed    = 8'h00;
   logic [7:0] ctrl_bits  = 8'h00;
   int         ctrl_idx   = 0;
   logic       ctrl_clk_q = 1'b0;

   always @(negedge clk) begin
      if (nes_latch) begin
         ctrl_bits = pressed;
         ctrl_idx  = 0;
      end else if (nes_clk && !ctrl_clk_q && ctrl_idx < 7) begin
         ctrl_idx++;
      end
      ctrl_clk_q = nes_clk;
   end

   assign nes_data = ~ctrl_bits[ctrl_idx[2:0]];

   // Reference: rising edges since reset release decide the frame position.
   int n = 0;
   always @(posedge clk or posedge reset) begin
      if (reset) n <= 0;
      else       n <= n + 1;
   end

   logic        check_en  = 1'b0;
   logic [7:0]  exp_cap   = 8'h00;
   logic [15:0] exp_input = 16'h0000;

   always @(posedge clk) begin
      #1;
      if (check_en) begin : compare
         int   u;
         logic e_latch, e_clk, e_fd;
         u       = n % FRAME;
         e_latch = (u >= LATCH_AT) && (u < SHIFT_AT);
         e_clk   = (u >= SHIFT_AT) && (((u - SHIFT_AT) % (2 * CLK_DIV)) < CLK_DIV);
         e_fd    = (n > FRAME) && (u == 1);
         if (reset) begin
            exp_input = 16'h0000;
         end else begin
            if (u == LATCH_AT + CLK_DIV) exp_cap = pressed;
            if (e_fd) exp_input = {8'h00, exp_cap};
         end
         check("model_latch", nes_latch, e_latch);
         check("model_clk", nes_clk, e_clk);
         check("model_frame_done", frame_done, e_fd);
         check("model_input", nes_input, exp_input);
         check("no_overlap", nes_latch & nes_clk, 1'b0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame_done(output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!frame_done && cycles < 400);
      check("frame_done_seen", frame_done, 1'b1);
   endtask

   // Button changes stay clear of the latch window so the capture is unambiguous.
   task automatic set_pressed(input logic [7:0] v);
      int u;
      @(negedge clk);
      u = n % FRAME;
      while (u >= LATCH_AT - 2 && u <= SHIFT_AT + 2) begin
         @(negedge clk);
         u = n % FRAME;
      end
      pressed = v;
   endtask

   int c;
   int guard;
   int run;
   int rises;
   logic cur;
   int his[$];
   int los[$];

   initial begin
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      @(negedge clk);
      check("reset_latch", nes_latch, 1'b0);
      check("reset_clk", nes_clk, 1'b0);
      check("reset_frame_done", frame_done, 1'b0);
      check("reset_input", nes_input, 16'h0000);

      // Start + Right pressed.
      pressed = 8'h88;
      @(negedge clk);
      reset = 1'b0;
      wait_frame_done(c);
      check("start_right", nes_input, 16'h0088);

      // Abort the second frame during CLK_HIGH.
      c = 0;
      while (!nes_clk && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("clk_high_seen", nes_clk, 1'b1);
      reset = 1'b1;
      #1;
      check("abort_latch", nes_latch, 1'b0);
      check("abort_clk", nes_clk, 1'b0);
      check("abort_frame_done", frame_done, 1'b0);
      check("abort_input", nes_input, 16'h0000);
      repeat (3) @(negedge clk);
      pressed = 8'h00;
      reset   = 1'b0;
      c = 0;
      while (!nes_latch && c < 200) begin
         step();
         c++;
      end
      check("latch_after_reset", c, 40);
      check("input_still_clear", nes_input, 16'h0000);

      // All released: empty word, fixed frame period.
      wait_frame_done(c);
      check("released", nes_input, 16'h0000);
      wait_frame_done(c);
      check("frame_period", c, 104);
      check("released_again", nes_input, 16'h0000);

      // Strobe timing over one frame.
      c = 0;
      while (!nes_latch && c < 200) begin
         step();
         c++;
      end
      c = 0;
      while (nes_latch && c < 50) begin
         step();
         c++;
      end
      check("latch_width", c, 8);
      cur = nes_clk;
      run = 0;
      guard = 0;
      rises = 0;
      while (!frame_done && guard < 200) begin
         step();
         guard++;
         run++;
         if (nes_clk && !cur) rises++;
         if (nes_clk !== cur || frame_done) begin
            if (cur) his.push_back(run);
            else     los.push_back(run);
            cur = nes_clk;
            run = 0;
         end
      end
      check("frame_done_after_pulses", frame_done, 1'b1);
      check("clk_pulses", his.size() + ((rises == 6) ? 0 : 100), 7);
      foreach (his[i]) check("clk_high_width", his[i], 4);
      for (int i = 0; i < 6 && i < los.size(); i++) check("clk_low_width", los[i], 4);

      // A-only, switched to B-only once bit 3 has been sampled.
      set_pressed(8'h01);
      rises = 0;
      guard = 0;
      cur = nes_clk;
      while (rises < 4 && guard < 400) begin
         step();
         guard++;
         if (nes_clk && !cur) rises++;
         cur = nes_clk;
      end
      check("fourth_clk_rise", rises, 4);
      set_pressed(8'h02);
      wait_frame_done(c);
      check("mid_change_frame", nes_input, 16'h0001);
      wait_frame_done(c);
      check("mid_change_next", nes_input, 16'h0002);

      // Fixed pattern held over five frames.
      set_pressed(8'h5A);
      wait_frame_done(c);
      for (int f = 0; f < 5; f++) begin
         wait_frame_done(c);
         check("hold_pattern", nes_input, 16'h005A);
      end

      // Random patterns, some changed mid-frame.
      for (int f = 0; f < 8; f++) begin
         set_pressed(8'($urandom_range(0, 255)));
         repeat ($urandom_range(1, 90)) @(negedge clk);
         if (f % 2 == 1) set_pressed(8'($urandom_range(0, 255)));
         wait_frame_done(c);
      end
      wait_frame_done(c);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/nes_controller_reader.md
NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

Interface
REQ-001 Parameter CLK_DIV, default 300: clk cycles per protocol tick (6 us at 50 MHz); legal range is 2 or more.
REQ-002 Parameter POLL_TICKS, default 2762: idle ticks between frames (about 60 Hz polling at the defaults).
REQ-003 Port clk, input, 1: single system clock; all flops rise-edge triggered.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port nes_data, input, 1: serial button data from the controller, active-low, asynchronous to clk.
REQ-006 Port nes_latch, output, 1: controller latch strobe, active-high.
REQ-007 Port nes_clk, output, 1: controller shift clock, idle low.
REQ-008 Port nes_input, output, 16: button word feeding register-bank r15, active-high.
REQ-009 Port frame_done, output, 1: one-cycle pulse when nes_input updates.

Function
REQ-010 nes_data SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-011 The tick divider SHALL be free-running, counting 0..CLK_DIV-1 and asserting an internal tick for one cycle at CLK_DIV-1.
REQ-012 The FSM SHALL change state only on tick cycles.
REQ-013 The FSM states SHALL be IDLE, LATCH, CLK_HIGH and CLK_LOW.
REQ-014 IDLE: outputs are low; the FSM counts POLL_TICKS ticks, then enters LATCH and clears the bit index.
REQ-015 LATCH: nes_latch is high for exactly 2 ticks (2*CLK_DIV cycles); on the tick ending LATCH, the FSM samples bit 0, then enters CLK_HIGH.
REQ-016 CLK_HIGH: nes_clk is high for 1 tick, then the FSM enters CLK_LOW.
REQ-017 CLK_LOW: nes_clk is low for 1 tick; on the ending tick, the FSM samples the next bit (index 1..7).
REQ-018 After bit 7 is sampled, the FSM SHALL return to IDLE; otherwise it SHALL return to CLK_HIGH.
REQ-019 Exactly 7 nes_clk pulses SHALL occur per frame.
REQ-020 Frame period SHALL be exactly (POLL_TICKS+16)*CLK_DIV clk cycles.
REQ-021 Sampled bits SHALL be inverted to active-high before storage, using this mapping:
- shift[0] = A
- shift[1] = B
- shift[2] = Select
- shift[3] = Start
- shift[4] = Up
- shift[5] = Down
- shift[6] = Left
- shift[7] = Right
REQ-022 On the clk cycle after bit 7 is sampled, nes_input SHALL load {8'h00, shift[7:0]} and frame_done SHALL pulse high for that one cycle.
REQ-023 nes_input SHALL hold its previous value throughout a frame; partial frames SHALL never be visible.
REQ-024 nes_input[15:8] SHALL always read 0.
REQ-025 nes_latch and nes_clk SHALL be driven from flops, with no combinational glitches.
REQ-026 nes_latch and nes_clk SHALL never be high simultaneously.

Reset
REQ-027 While reset is high, the following SHALL hold:
- state = IDLE
- divider, idle counter, bit index and shift register = 0
- synchronizer flops = 1 (released)
- nes_input = 16'h0000
- nes_latch, nes_clk and frame_done = 0
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; nes_input SHALL stay 0 until the first complete post-reset frame.
REQ-029 After reset deasserts, the first LATCH SHALL begin after POLL_TICKS ticks.

Verification (bench uses CLK_DIV=4, POLL_TICKS=10, and a shift-register controller model)
REQ-030 Reset: pulse reset during CLK_HIGH of the second frame -> nes_clk, nes_latch and frame_done drop at once, nes_input=16'h0000, and the next latch rises 40 cycles after reset release.
REQ-031 Pattern: model presents Start+Right pressed (serial stream 1,1,1,0,1,1,1,0 from A to Right) -> after frame_done, nes_input=16'h0088.
REQ-032 All released (nes_data held high) -> nes_input=16'h0000, one frame_done per 104 cycles.
REQ-033 Timing: nes_latch high for 8 cycles; 7 nes_clk pulses, each 4 cycles high and 4 cycles low; the two strobes never overlap.
REQ-034 Mid-frame change: switch the model from A-only to B-only after bit 3 is sampled -> nes_input shows 16'h0001 for that frame and 16'h0002 after the next frame.
REQ-035 Hold: for a fixed pattern across 5 frames, nes_input never changes except on frame_done cycles.
